sb_rx_decoder: RTL



---
 rtl/sb_rx_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sb_rx_decoder.sv
// Sideband receive decoder: recovers UART-style bytes from sbrx, strips
// DLE/STX/ETX framing, checks LT complements, unstuffs AT payloads and
// reports each finished transaction or error as a single-cycle strobe.
module sb_rx_decoder #(
    parameter int MAX_AT_BYTES   = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int LEN_W         = $clog2(MAX_AT_BYTES + 1)
) (
    input  logic                      sb_clk,
    input  logic                      rst,
    input  logic                      sbrx,
    output logic                      lt_valid,
    output logic [7:0]                lt_lse,
    output logic                      at_valid,
    output logic [8*MAX_AT_BYTES-1:0] at_data,
    output logic [LEN_W-1:0]          at_len,
    output logic                      err,
    output logic [2:0]                err_code
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] DLE = 8'hFE;
    localparam logic [7:0] STX = 8'h05;
    localparam logic [7:0] ETX = 8'h40;

    typedef enum logic [1:0] {
        B_IDLE,
        B_DATA,
        B_STOP,
        B_WAIT_HIGH
    } byte_state_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_TYPE,
        F_CLSE,
        F_LT_DLE,
        F_LT_ETX,
        F_AT,
        F_AT_ESC
    } frame_state_t;

    byte_state_t byte_state_q, byte_state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_stb_q, byte_stb_d;
    logic [7:0]  byte_q, byte_d;
    logic        frm_err_q, frm_err_d;
    logic        idle_tick_q, idle_tick_d;

    logic        stb_dly_q, stb_dly_d;
    logic [7:0]  byte_dly_q, byte_dly_d;
    logic        frm_err_dly_q, frm_err_dly_d;
    logic        tick_dly_q, tick_dly_d;

    frame_state_t              frame_state_q, frame_state_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic [7:0]                lse_q, lse_d;
    logic [8*MAX_AT_BYTES-1:0] shadow_q, shadow_d;
    logic [TO_W-1:0]           idle_cnt_q, idle_cnt_d;
    logic                      lt_valid_q, lt_valid_d;
    logic [7:0]                lt_lse_q, lt_lse_d;
    logic                      at_valid_q, at_valid_d;
    logic [8*MAX_AT_BYTES-1:0] at_data_q, at_data_d;
    logic [LEN_W-1:0]          at_len_q, at_len_d;
    logic                      err_q, err_d;
    logic [2:0]                err_code_q, err_code_d;
    logic                      do_store;
    logic [7:0]                store_val;

    // Byte recovery: start bit, eight data bits LSB first, then stop-bit check.
    always_comb begin
        byte_state_d = byte_state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_stb_d   = 1'b0;
        byte_d       = byte_q;
        frm_err_d    = 1'b0;
        idle_tick_d  = 1'b0;
        case (byte_state_q)
            B_IDLE: begin
                idle_tick_d = sbrx;
                if (!sbrx) begin
                    byte_state_d = B_DATA;
                    bit_cnt_d    = 3'd0;
                end
            end
            B_DATA: begin
                shift_d   = {sbrx, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_state_d = B_STOP;
                end
            end
            B_STOP: begin
                if (sbrx) begin
                    byte_stb_d   = 1'b1;
                    byte_d       = shift_q;
                    byte_state_d = B_IDLE;
                end else begin
                    frm_err_d    = 1'b1;
                    byte_state_d = B_WAIT_HIGH;
                end
            end
            B_WAIT_HIGH: begin
                if (sbrx) begin
                    byte_state_d = B_IDLE;
                end
            end
            default: byte_state_d = B_IDLE;
        endcase
    end

    // Byte recovery state and its per-sample event flags.
    always_ff @(posedge sb_clk) begin
        if (!rst) begin
            byte_state_q <= B_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_stb_q   <= 1'b0;
            byte_q       <= '0;
            frm_err_q    <= 1'b0;
            idle_tick_q  <= 1'b0;
        end else begin
            byte_state_q <= byte_state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_stb_q   <= byte_stb_d;
            byte_q       <= byte_d;
            frm_err_q    <= frm_err_d;
            idle_tick_q  <= idle_tick_d;
        end
    end

    // Alignment stage so every strobe lands two edges after its causing sample.
    always_comb begin
        stb_dly_d     = byte_stb_q;
        byte_dly_d    = byte_q;
        frm_err_dly_d = frm_err_q;
        tick_dly_d    = idle_tick_q;
    end

    // Alignment registers between byte recovery and frame decoding.
    always_ff @(posedge sb_clk) begin
        if (!rst) begin
            stb_dly_q     <= 1'b0;
            byte_dly_q    <= '0;
            frm_err_dly_q <= 1'b0;
            tick_dly_q    <= 1'b0;
        end else begin
            stb_dly_q     <= stb_dly_d;
            byte_dly_q    <= byte_dly_d;
            frm_err_dly_q <= frm_err_dly_d;
            tick_dly_q    <= tick_dly_d;
        end
    end

    // Frame decoding with error priority framing > timeout > frame-level.
    always_comb begin
        frame_state_d = frame_state_q;
        cnt_d         = cnt_q;
        lse_d         = lse_q;
        shadow_d      = shadow_q;
        idle_cnt_d    = idle_cnt_q;
        lt_valid_d    = 1'b0;
        lt_lse_d      = lt_lse_q;
        at_valid_d    = 1'b0;
        at_data_d     = at_data_q;
        at_len_d      = at_len_q;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        do_store      = 1'b0;
        store_val     = byte_dly_q;
        if (frm_err_dly_q) begin
            err_d         = 1'b1;
            err_code_d    = 3'd1;
            frame_state_d = F_IDLE;
            idle_cnt_d    = '0;
        end else if (tick_dly_q && (frame_state_q != F_IDLE)) begin
            if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                err_d         = 1'b1;
                err_code_d    = 3'd6;
                frame_state_d = F_IDLE;
                idle_cnt_d    = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end else if (stb_dly_q) begin
            idle_cnt_d = '0;
            case (frame_state_q)
                F_IDLE: begin
                    if (byte_dly_q == DLE) begin
                        frame_state_d = F_TYPE;
                    end
                end
                F_TYPE: begin
                    if (byte_dly_q == STX) begin
                        frame_state_d = F_AT;
                        cnt_d         = '0;
                        shadow_d      = '0;
                    end else if (byte_dly_q == DLE) begin
                        frame_state_d = F_TYPE;
                    end else if (byte_dly_q == ETX) begin
                        frame_state_d = F_IDLE;
                    end else begin
                        lse_d         = byte_dly_q;
                        frame_state_d = F_CLSE;
                    end
                end
                F_CLSE: begin
                    if (byte_dly_q == ~lse_q) begin
                        frame_state_d = F_LT_DLE;
                    end else begin
                        err_d         = 1'b1;
                        err_code_d    = 3'd2;
                        frame_state_d = F_IDLE;
                    end
                end
                F_LT_DLE: begin
                    if (byte_dly_q == DLE) begin
                        frame_state_d = F_LT_ETX;
                    end else begin
                        err_d         = 1'b1;
                        err_code_d    = 3'd3;
                        frame_state_d = F_IDLE;
                    end
                end
                F_LT_ETX: begin
                    if (byte_dly_q == ETX) begin
                        lt_valid_d = 1'b1;
                        lt_lse_d   = lse_q;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 3'd3;
                    end
                    frame_state_d = F_IDLE;
                end
                F_AT: begin
                    if (byte_dly_q == DLE) begin
                        frame_state_d = F_AT_ESC;
                    end else begin
                        do_store = 1'b1;
                    end
                end
                F_AT_ESC: begin
                    if (byte_dly_q == DLE) begin
                        do_store  = 1'b1;
                        store_val = DLE;
                    end else if (byte_dly_q == ETX) begin
                        if (cnt_q != '0) begin
                            at_valid_d = 1'b1;
                            at_len_d   = cnt_q;
                            at_data_d  = shadow_q;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = 3'd7;
                        end
                        frame_state_d = F_IDLE;
                    end else begin
                        err_d         = 1'b1;
                        err_code_d    = 3'd5;
                        frame_state_d = F_IDLE;
                    end
                end
                default: frame_state_d = F_IDLE;
            endcase
            if (do_store) begin
                if (cnt_q == LEN_W'(MAX_AT_BYTES)) begin
                    err_d         = 1'b1;
                    err_code_d    = 3'd4;
                    frame_state_d = F_IDLE;
                end else begin
                    for (int i = 0; i < MAX_AT_BYTES; i++) begin
                        if (cnt_q == LEN_W'(i)) begin
                            shadow_d[8*i +: 8] = store_val;
                        end
                    end
                    cnt_d         = cnt_q + 1'b1;
                    frame_state_d = F_AT;
                end
            end
        end
    end

    // Frame state, staging buffer and registered outputs.
    always_ff @(posedge sb_clk) begin
        if (!rst) begin
            frame_state_q <= F_IDLE;
            cnt_q         <= '0;
            lse_q         <= '0;
            shadow_q      <= '0;
            idle_cnt_q    <= '0;
            lt_valid_q    <= 1'b0;
            lt_lse_q      <= '0;
            at_valid_q    <= 1'b0;
            at_data_q     <= '0;
            at_len_q      <= '0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
        end else begin
            frame_state_q <= frame_state_d;
            cnt_q         <= cnt_d;
            lse_q         <= lse_d;
            shadow_q      <= shadow_d;
            idle_cnt_q    <= idle_cnt_d;
            lt_valid_q    <= lt_valid_d;
            lt_lse_q      <= lt_lse_d;
            at_valid_q    <= at_valid_d;
            at_data_q     <= at_data_d;
            at_len_q      <= at_len_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign lt_valid = lt_valid_q;
    assign lt_lse   = lt_lse_q;
    assign at_valid = at_valid_q;
    assign at_data  = at_data_q;
    assign at_len   = at_len_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
